// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects the active-low push button and slide switches.
// Optional auto-repeat of key_press while held: define INPUT_CONDITIONER_AUTOREPEAT_EN.
module input_conditioner #(
  parameter int unsigned SW_WIDTH        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                key_n,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic                key_level,
  output logic                key_press,
  output logic                key_release,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic                sw_changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("input_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_t;

  logic                key_s1, key_s2;
  logic [SW_WIDTH-1:0] sw_s1, sw_s2, sw_prev;

  // Two-flop synchronizers; the key chain idles released (1).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
    end
  end

  key_state_t       state, state_d;
  logic [CNT_W-1:0] key_cnt, key_cnt_d, key_inc_c;
  logic             key_down_c, level_d, accept_c, release_d, press_d, repeat_fire_c;

  assign key_down_c = ~key_s2;
  assign key_inc_c  = (key_cnt == CNT_MAX) ? key_cnt : key_cnt + CNT_ONE;
  assign press_d    = accept_c | repeat_fire_c;

  always_comb begin
    state_d   = state;
    key_cnt_d = key_cnt;
    level_d   = key_level;
    accept_c  = 1'b0;
    release_d = 1'b0;
    case (state)
      RELEASED: begin
        if (key_down_c) begin
          if (CNT_ONE == CNT_MAX) begin
            state_d  = PRESSED;
            level_d  = 1'b1;
            accept_c = 1'b1;
          end else begin
            state_d   = PRESS_WAIT;
            key_cnt_d = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!key_down_c) begin
          state_d   = RELEASED;
          key_cnt_d = '0;
        end else if (key_inc_c == CNT_MAX) begin
          state_d   = PRESSED;
          key_cnt_d = '0;
          level_d   = 1'b1;
          accept_c  = 1'b1;
        end else begin
          key_cnt_d = key_inc_c;
        end
      end
      PRESSED: begin
        if (!key_down_c) begin
          if (CNT_ONE == CNT_MAX) begin
            state_d   = RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d   = RELEASE_WAIT;
            key_cnt_d = CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (key_down_c) begin
          state_d   = PRESSED;
          key_cnt_d = '0;
        end else if (key_inc_c == CNT_MAX) begin
          state_d   = RELEASED;
          key_cnt_d = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          key_cnt_d = key_inc_c;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RELEASED;
      key_cnt     <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_d;
      key_cnt     <= key_cnt_d;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d, hold_inc_c, hold_target_c;
  logic              repeating, repeating_d, hold_run_c;

  // Hold time only advances while settled in PRESSED; RELEASE_WAIT freezes it.
  assign hold_run_c    = (state == PRESSED) && key_down_c;
  assign hold_inc_c    = hold_cnt + HOLD_W'(1);
  assign hold_target_c = repeating ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY);

  always_comb begin
    hold_cnt_d    = hold_cnt;
    repeating_d   = repeating;
    repeat_fire_c = 1'b0;
    if (!level_d) begin
      hold_cnt_d  = '0;
      repeating_d = 1'b0;
    end else if (hold_run_c) begin
      if (hold_inc_c == hold_target_c) begin
        repeat_fire_c = 1'b1;
        hold_cnt_d    = '0;
        repeating_d   = 1'b1;
      end else begin
        hold_cnt_d = hold_inc_c;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_d;
      repeating <= repeating_d;
    end
  end
`else
  assign repeat_fire_c = 1'b0;
`endif

  logic [CNT_W-1:0]    sw_cnt, sw_cnt_d, sw_cand_c;
  logic [SW_WIDTH-1:0] stable_d;
  logic                changed_d;

  // A fresh vector restarts the count at 1; an unchanged one keeps counting (saturating).
  assign sw_cand_c = (sw_s2 != sw_prev) ? CNT_ONE
                   : ((sw_cnt == CNT_MAX) ? sw_cnt : sw_cnt + CNT_ONE);

  always_comb begin
    sw_cnt_d  = sw_cnt;
    stable_d  = sw_stable;
    changed_d = 1'b0;
    if (sw_s2 == sw_stable) begin
      sw_cnt_d = '0;
    end else if (sw_cand_c == CNT_MAX) begin
      sw_cnt_d  = '0;
      stable_d  = sw_s2;
      changed_d = 1'b1;
    end else begin
      sw_cnt_d = sw_cand_c;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_prev    <= '0;
      sw_cnt     <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_prev    <= sw_s2;
      sw_cnt     <= sw_cnt_d;
      sw_stable  <= stable_d;
      sw_changed <= changed_d;
    end
  end

endmodule
